// File: rtl/logic_exec_stage.sv
`default_nettype none
// ------------------------------------------------------------------------
// logic_exec_stage : registered 16-bit AND/OR/XOR/NOT stage with result FIFO
// Revision: 1.0
// ------------------------------------------------------------------------
module logic_exec_stage #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_neg,
  input  logic             clear_count,
  output logic [15:0]      op_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);

  // Entry layout: {zero, neg, data}
  logic [WIDTH+1:0] fifo_mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    occupancy;
  logic [WIDTH-1:0] result;
  logic [WIDTH+1:0] head;
  logic             push;
  logic             pop;

  always_comb begin
    result = '0;
    case (in_op)
      2'b00: result = in_x & in_y;
      2'b01: result = in_x | in_y;
      2'b10: result = in_x ^ in_y;
      2'b11: result = ~in_x;
    endcase
  end

  // Ready looks only at registered occupancy, so a pop never frees a slot
  // in the same cycle.
  assign in_ready  = (occupancy < FULL_LEVEL);
  assign out_valid = (occupancy != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign head      = fifo_mem[rd_ptr];

  assign out_data = out_valid ? head[WIDTH-1:0] : '0;
  assign out_neg  = out_valid ? head[WIDTH]     : 1'b0;
  assign out_zero = out_valid ? head[WIDTH+1]   : 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
      op_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {(result == '0), result[WIDTH-1], result};
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   occupancy <= occupancy + CW'(1);
        2'b01:   occupancy <= occupancy - CW'(1);
        default: occupancy <= occupancy;
      endcase
      // A clear coinciding with an accept still counts that accept.
      if (clear_count) begin
        op_count <= {15'd0, push};
      end else if (push) begin
        op_count <= op_count + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_logic_exec_stage.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_logic_exec_stage : scoreboard bench for logic_exec_stage
// Revision: 1.0
// ------------------------------------------------------------------------
module tb_logic_exec_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x;
  logic [15:0] in_y;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_zero;
  logic        out_neg;
  logic        clear_count;
  logic [15:0] op_count;

  int checks = 0;
  int errors = 0;
  logic [17:0] sb [$];

  logic_exec_stage #(.WIDTH(16), .DEPTH(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .in_y        (in_y),
    .in_op       (in_op),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_zero    (out_zero),
    .out_neg     (out_neg),
    .clear_count (clear_count),
    .op_count    (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected entry {zero, neg, data} from a hand-computed result value.
  function automatic logic [17:0] ent(input logic [15:0] d);
    return {(d == 16'h0000), d[15], d};
  endfunction

  function automatic logic [15:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic [1:0] op);
    case (op)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~x;
    endcase
  endfunction

  // Monitor: compares every consumed head against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!out_valid) begin
        chk("empty_outputs", {14'd0, out_zero, out_neg, out_data}, 32'd0);
      end else if (out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got data 0x%0h expected no output", out_data);
        end else begin
          logic [17:0] e;
          e = sb.pop_front();
          chk("out_data", {16'd0, out_data}, {16'd0, e[15:0]});
          chk("out_zero", {31'd0, out_zero}, {31'd0, e[17]});
          chk("out_neg",  {31'd0, out_neg},  {31'd0, e[16]});
        end
      end
    end
  end

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [1:0] op,
                      input logic [15:0] exp_d);
    bit done;
    done = 0;
    in_x = x; in_y = y; in_op = op; in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(ent(exp_d));
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready 0 expected 1");
    end else begin
      chk("latency_valid", {31'd0, out_valid}, 32'd1);
    end
  endtask

  task automatic drain();
    bit done;
    done = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) done = 1;
    end
    @(posedge clk);
    #1;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic pulse_clear();
    clear_count = 1'b1;
    @(posedge clk);
    #1;
    clear_count = 1'b0;
  endtask

  initial begin
    int acc;
    logic [15:0] first_exp;
    rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_op = '0;
    out_ready = 1'b0; clear_count = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_flags", {30'd0, out_zero, out_neg}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_op_count", {16'd0, op_count}, 32'd0);
    @(posedge clk);
    #1;

    // Basic ops
    out_ready = 1'b1;
    send(16'h00FF, 16'h0F0F, 2'b00, 16'h000F);
    send(16'h00FF, 16'h0F0F, 2'b01, 16'h0FFF);
    send(16'h00FF, 16'h0F0F, 2'b10, 16'h0FF0);
    send(16'h00FF, 16'h0F0F, 2'b11, 16'hFF00);
    drain();

    // Flags
    send(16'hAAAA, 16'h5555, 2'b00, 16'h0000);
    send(16'hAAAA, 16'h5555, 2'b01, 16'hFFFF);
    drain();

    // Backpressure / full
    out_ready = 1'b0;
    acc = 0;
    in_x = 16'h1230; in_y = 16'h00FF; in_op = 2'b10; in_valid = 1'b1;
    first_exp = 16'h12CF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(ent(model(in_x, in_y, in_op)));
        acc++;
      end
      @(posedge clk);
      #1;
      in_x = in_x + 16'd1;
    end
    in_valid = 1'b0;
    chk("full_accepts", acc, 32'd2);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("head_hold", {15'd0, out_valid, out_data}, {16'd1, first_exp});
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk("full_ready_with_pop", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("ready_after_pop", {31'd0, in_ready}, 32'd1);
    drain();

    // Continuous stream at occupancy 1
    pulse_clear();
    chk("clear_alone", {16'd0, op_count}, 32'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_x = 16'h0135 * 16'(i + 1); in_y = 16'hF0F0; in_op = 2'(i);
      @(negedge clk);
      chk("stream_ready", {31'd0, in_ready}, 32'd1);
      if (i > 0) chk("stream_valid", {31'd0, out_valid}, 32'd1);
      if (in_ready) sb.push_back(ent(model(in_x, in_y, in_op)));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain();
    chk("stream_op_count", {16'd0, op_count}, 32'd10);

    // Counter wrap
    pulse_clear();
    acc = 0;
    in_x = 16'h0001; in_y = 16'h0000; in_op = 2'b01; in_valid = 1'b1;
    for (int i = 0; i < 70000 && acc < 65535; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(ent(16'h0001));
        acc++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("count_ffff", {16'd0, op_count}, 32'h0000FFFF);
    send(16'h0001, 16'h0000, 2'b01, 16'h0001);
    chk("count_wrap", {16'd0, op_count}, 32'd0);
    send(16'h0003, 16'h0000, 2'b01, 16'h0003);
    in_x = 16'h8000; in_y = 16'h0000; in_op = 2'b10;
    clear_count = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    chk("clr_acc_ready", {31'd0, in_ready}, 32'd1);
    if (in_ready) sb.push_back(ent(16'h8000));
    @(posedge clk);
    #1 clear_count = 1'b0; in_valid = 1'b0;
    chk("clear_with_accept", {16'd0, op_count}, 32'd1);
    pulse_clear();
    chk("clear_alone2", {16'd0, op_count}, 32'd0);
    drain();

    // Reset mid-stream
    out_ready = 1'b0;
    send(16'h1111, 16'h2222, 2'b01, 16'h3333);
    send(16'h1111, 16'h2222, 2'b10, 16'h3333);
    chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    sb.delete();
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_data", {16'd0, out_data}, 32'd0);
    chk("mid_rst_count", {16'd0, op_count}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_stale", {31'd0, out_valid}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/logic_exec_stage.md
Name: logic_exec_stage

Overview:
- Registered execution stage that wraps the 16-bit bitwise logic function (AND/OR/XOR/NOT-X) with valid/ready handshakes on both sides.
- Operand requests enter from the decode/operand-fetch side and are evaluated with the standard op encoding.
- Each result is pushed with zero/negative flags into a small result FIFO that drains to the writeback side.
- Keeps a running count of accepted operations for debug and performance readout.

Parameters:
- WIDTH, 16, data width of operands and result.
- DEPTH, 2, result FIFO entries; must be a power of two and at least 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand request present.
- in_ready  output  1  stage can accept a request this cycle.
- in_x  input  WIDTH  operand X.
- in_y  input  WIDTH  operand Y.
- in_op  input  2  {op1,op0}: 00 X&Y, 01 X|Y, 10 X^Y, 11 ~X (Y ignored).
- out_valid  output  1  result at FIFO head is valid.
- out_ready  input  1  consumer takes the head result this cycle.
- out_data  output  WIDTH  head result.
- out_zero  output  1  head result == 0.
- out_neg  output  1  head result MSB.
- clear_count  input  1  synchronous clear of op_count.
- op_count  output  16  accepted-operation counter.

Behaviour:
- Reset (rst_n low at a rising edge):
  - FIFO occupancy, read pointer and write pointer go to 0.
  - All FIFO entries clear to 0.
  - op_count goes to 0.
  - After reset: out_valid=0, out_data=0, out_zero=0, out_neg=0, in_ready=1.
  - Reset mid-operation discards all buffered results; nothing is emitted afterwards.
- Accept:
  - accept = in_valid & in_ready.
  - in_ready = (occupancy < DEPTH), a pure function of registered occupancy. It does not depend on out_ready, so there is no combinational ready path.
  - On accept, the result is computed combinationally from in_x/in_y/in_op and written at the write pointer together with its flags:
    - zero = (result == 0).
    - neg = result[WIDTH-1].
- Latency:
  - A result accepted at edge N is visible with out_valid=1 after edge N (exactly 1 cycle).
  - There is no same-cycle bypass from input to output.
- Output:
  - out_valid = (occupancy != 0).
  - out_data/out_zero/out_neg show the head entry when out_valid=1, and are forced to 0 when the FIFO is empty.
  - pop = out_valid & out_ready.
  - The head stays stable while out_valid=1 and out_ready=0.
- Occupancy update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, both pointers advance.
  - Push while full cannot occur because in_ready=0.
  - Pop while empty is ignored; out_ready has no effect when out_valid=0.
- Pointers: wrap modulo DEPTH.
- Full condition:
  - With occupancy == DEPTH, in_ready=0 even if out_ready=1 in that cycle.
  - in_ready rises the cycle after a pop.
- Order: strict FIFO; results leave in acceptance order.
- op_count:
  - Increments by 1 on each accept and wraps 0xFFFF -> 0x0000.
  - clear_count=1 with no accept: next value 0.
  - clear_count=1 with an accept in the same cycle: next value 1.
  - Not affected by pops.
- in_op with unknown/X bits: result is unspecified. Benches drive only the four legal codes.

Test Plan:
- Basic ops: after reset, x=0x00FF, y=0x0F0F, hold out_ready=1, issue the ops in order 00/01/10/11.
  - Required outputs, each 1 cycle after its accept: 0x000F, 0x0FFF, 0x0FF0, 0xFF00.
  - 0xFF00 reports neg=1, zero=0.
- Flags: x=0xAAAA, y=0x5555, op=00.
  - Required: out_data=0x0000, zero=1, neg=0.
  - Then op=01 with the same operands: 0xFFFF, zero=0, neg=1.
- Backpressure/full: out_ready=0 with in_valid held high.
  - Exactly 2 accepts occur, then in_ready=0.
  - The head holds the first result unchanged for 5 cycles.
  - Raise out_ready: the results drain in order, and in_ready returns 1 the cycle after the first pop.
- Simultaneous push/pop at occupancy 1 with continuous traffic:
  - Occupancy stays 1 and throughput is 1 result/cycle.
  - A 10-request stream yields 10 ordered results, and op_count=10.
- Counter: preload by 0xFFFF accepts, or by forcing via 65535 ops.
  - The next accept wraps op_count to 0x0000.
  - clear_count pulsed together with an accept gives op_count=1.
  - clear_count alone gives 0.
- Reset mid-stream: with 2 results buffered, assert rst_n=0 for 1 cycle.
  - Required: out_valid=0, out_data=0, op_count=0, in_ready=1.
  - No stale result appears afterwards.
